// File: rtl/phase_word_merger.sv
// Reassembles four one-hot-phased samples into one wide word and queues it in a 2-entry FIFO.
// Optional PHASE_ERR_CNT_EN adds an 8-bit saturating phase_err counter on port err_cnt.
module phase_word_merger #(
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            CLKin,
    input  logic            rst,
    input  logic [3:0]      phase,
    input  logic [DW-1:0]   din,
    output logic [4*DW-1:0] word_out,
    output logic            word_valid,
    input  logic            word_ready,
    output logic            locked,
    output logic            phase_err,
    output logic            overflow
`ifdef PHASE_ERR_CNT_EN
    ,
    output logic [7:0]      err_cnt
`endif
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StHunt, StTrack} state_e;

    state_e              state_q, state_d;
    logic [3:0]          exp_phase_q, exp_phase_d;
    logic [3*DW-1:0]     part_q, part_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic                phase_err_q, phase_err_d;
    logic                push;
    logic [4*DW-1:0]     push_word;

    logic [4*DW-1:0]     mem_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          cnt_q;
    logic                overflow_q;
    logic                pop, push_ok, drop;

    // Sequencer tracking: lanes 0..2 are staged, lane 3 comes straight from din.
    always_comb begin
        state_d     = state_q;
        exp_phase_d = exp_phase_q;
        part_d      = part_q;
        idle_d      = idle_q;
        phase_err_d = 1'b0;
        push        = 1'b0;
        push_word   = {din, part_q};

        unique case (state_q)
            StHunt: begin
                if (phase == 4'h1) begin
                    part_d      = {{(2*DW){1'b0}}, din};
                    exp_phase_d = 4'h2;
                    idle_d      = '0;
                    state_d     = StTrack;
                end
            end
            StTrack: begin
                if (phase == exp_phase_q) begin
                    idle_d      = '0;
                    exp_phase_d = {exp_phase_q[2:0], exp_phase_q[3]};
                    case (exp_phase_q)
                        4'h1:    part_d[DW-1:0]      = din;
                        4'h2:    part_d[2*DW-1:DW]   = din;
                        4'h4:    part_d[3*DW-1:2*DW] = din;
                        default: begin
                            push   = 1'b1;
                            part_d = '0;
                        end
                    endcase
                end else if (phase == 4'h0) begin
                    // Saturating idle count; hitting TIMEOUT silently drops lock.
                    if (idle_q != IW'(TIMEOUT)) begin
                        idle_d = idle_q + IW'(1);
                    end
                    if (idle_d == IW'(TIMEOUT)) begin
                        state_d     = StHunt;
                        part_d      = '0;
                        exp_phase_d = 4'h1;
                    end
                end else if (phase == 4'h1) begin
                    // Early restart: resynchronise on the new phase-1 sample without leaving TRACK.
                    phase_err_d = 1'b1;
                    part_d      = {{(2*DW){1'b0}}, din};
                    exp_phase_d = 4'h2;
                    idle_d      = '0;
                end else begin
                    phase_err_d = 1'b1;
                    part_d      = '0;
                    exp_phase_d = 4'h1;
                    state_d     = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge CLKin) begin
        if (rst) begin
            state_q     <= StHunt;
            exp_phase_q <= 4'h1;
            part_q      <= '0;
            idle_q      <= '0;
            phase_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_phase_q <= exp_phase_d;
            part_q      <= part_d;
            idle_q      <= idle_d;
            phase_err_q <= phase_err_d;
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign pop     = (cnt_q != 2'd0) && word_ready;
    assign push_ok = push && ((cnt_q != 2'd2) || pop);
    assign drop    = push && !push_ok;

    always_ff @(posedge CLKin) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(push_ok) - 2'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign word_out   = mem_q[rd_ptr_q];
    assign word_valid = (cnt_q != 2'd0);
    assign locked     = (state_q == StTrack);
    assign phase_err  = phase_err_q;
    assign overflow   = overflow_q;

`ifdef PHASE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge CLKin) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (phase_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_phase_word_merger.sv
// Directed bench for phase_word_merger with a word scoreboard checked on each handshake.
module tb_phase_word_merger;

    logic        CLKin;
    logic        rst;
    logic [3:0]  phase;
    logic [7:0]  din;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        locked;
    logic        phase_err;
    logic        overflow;
`ifdef PHASE_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned perr_pulses = 0;
    int unsigned words_seen  = 0;
    int unsigned p0;
    logic [31:0] sb [$];

    phase_word_merger #(.DW(8), .TIMEOUT(15)) dut (
        .CLKin      (CLKin),
        .rst        (rst),
        .phase      (phase),
        .din        (din),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .phase_err  (phase_err),
        .overflow   (overflow)
`ifdef PHASE_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial CLKin = 1'b0;
    always #5 CLKin = ~CLKin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] ph, input logic [7:0] d);
        phase = ph;
        din   = d;
        @(posedge CLKin);
        #1;
        if (phase_err === 1'b1) perr_pulses++;
    endtask

    task automatic send_word(input logic [31:0] w, input bit kept);
        step(4'h1, w[7:0]);
        step(4'h2, w[15:8]);
        step(4'h4, w[23:16]);
        if (kept) sb.push_back(w);
        step(4'h8, w[31:24]);
    endtask

    // Scoreboard: every accepted word must match the oldest expected one.
    always @(negedge CLKin) begin
        if (!rst && word_valid && word_ready) begin
            words_seen++;
            if (sb.size() == 0) begin
                check("unexpected_word", word_out, 32'hx);
            end else begin
                check("word_out", word_out, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; phase = 4'h0; din = 8'h00; word_ready = 1'b0;
        step(4'h0, 8'h00);
        step(4'h0, 8'h00);
        rst = 1'b0;
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_perr", {31'd0, phase_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_word", word_out, 32'd0);

        // 1: basic word
        word_ready = 1'b1;
        step(4'h1, 8'h11);
        check("t1_locked", {31'd0, locked}, 32'd1);
        step(4'h2, 8'h22);
        step(4'h4, 8'h33);
        check("t1_no_valid_early", {31'd0, word_valid}, 32'd0);
        sb.push_back(32'h44332211);
        step(4'h8, 8'h44);
        check("t1_valid", {31'd0, word_valid}, 32'd1);
        check("t1_word", word_out, 32'h44332211);
        step(4'h0, 8'h00);
        check("t1_valid_drop", {31'd0, word_valid}, 32'd0);
        check("t1_words_seen", words_seen, 32'd1);

        // 2: wrong lane
        p0 = perr_pulses;
        step(4'h1, 8'h01);
        step(4'h2, 8'h02);
        step(4'h8, 8'h08);
        check("t2_perr", {31'd0, phase_err}, 32'd1);
        check("t2_locked", {31'd0, locked}, 32'd0);
        check("t2_no_word", {31'd0, word_valid}, 32'd0);
        step(4'h0, 8'h00);
        check("t2_perr_pulse", {31'd0, phase_err}, 32'd0);
        check("t2_perr_count", perr_pulses - p0, 32'd1);

        // HUNT ignores non-phase-1 strobes
        p0 = perr_pulses;
        step(4'h4, 8'h55);
        check("hunt_ignore_lock", {31'd0, locked}, 32'd0);
        check("hunt_ignore_perr", perr_pulses - p0, 32'd0);

        // Early phase 1 restarts the word while staying locked
        step(4'h1, 8'h91);
        step(4'h2, 8'h92);
        step(4'h1, 8'hA1);
        check("restart_perr", {31'd0, phase_err}, 32'd1);
        check("restart_locked", {31'd0, locked}, 32'd1);
        step(4'h2, 8'hA2);
        step(4'h4, 8'hA4);
        sb.push_back(32'hA8A4A2A1);
        step(4'h8, 8'hA8);
        check("restart_valid", {31'd0, word_valid}, 32'd1);
        step(4'h0, 8'h00);

        // Multi-hot strobe drops lock
        p0 = perr_pulses;
        step(4'h1, 8'h00);
        step(4'h3, 8'h00);
        check("multihot_perr", perr_pulses - p0, 32'd1);
        check("multihot_locked", {31'd0, locked}, 32'd0);

        // 3: backpressure and overflow
        word_ready = 1'b0;
        send_word(32'hA3A2A1A0, 1'b1);
        send_word(32'hB3B2B1B0, 1'b1);
        check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        send_word(32'hC3C2C1C0, 1'b0);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_valid", {31'd0, word_valid}, 32'd1);
        check("t3_head", word_out, sb[0]);
        step(4'h0, 8'h00);
        check("t3_head_stable", word_out, 32'hA3A2A1A0);
        word_ready = 1'b1;
        step(4'h0, 8'h00);
        step(4'h0, 8'h00);
        check("t3_drained", {31'd0, word_valid}, 32'd0);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        check("t3_sb_empty", sb.size(), 32'd0);

        // 4: idle timeout
        p0 = perr_pulses;
        step(4'h1, 8'h01);
        step(4'h2, 8'h02);
        for (int i = 0; i < 14; i++) step(4'h0, 8'h00);
        check("t4_locked_14", {31'd0, locked}, 32'd1);
        step(4'h0, 8'h00);
        check("t4_unlocked_15", {31'd0, locked}, 32'd0);
        check("t4_no_perr", perr_pulses - p0, 32'd0);

        // 5: reset mid-word
        step(4'h1, 8'h77);
        step(4'h2, 8'h78);
        rst = 1'b1;
        step(4'h0, 8'h00);
        rst = 1'b0;
        check("t5_locked", {31'd0, locked}, 32'd0);
        check("t5_valid", {31'd0, word_valid}, 32'd0);
        check("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        send_word(32'hDDCCBBAA, 1'b1);
        check("t5_valid_after", {31'd0, word_valid}, 32'd1);
        step(4'h0, 8'h00);
        check("t5_sb_empty", sb.size(), 32'd0);

        // 6: error counter saturation
        p0 = perr_pulses;
        for (int i = 0; i < 300; i++) begin
            step(4'h1, 8'h00);
            step(4'h4, 8'h00);
        end
        check("t6_pulses", perr_pulses - p0, 32'd300);
`ifdef PHASE_ERR_CNT_EN
        check("t6_err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        rst = 1'b1;
        step(4'h0, 8'h00);
        rst = 1'b0;
        check("t6_err_cnt_rst", {24'd0, err_cnt}, 32'd0);
`endif
        check("words_total", words_seen, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
